// File: rtl/alu_op_decoder_pkg.sv
// Shared types for the RV32I ALU operation decoder: ALU control codes, operand
// selects, opcode constants, the decoded payload and the immediate formatters.
package alu_op_decoder_pkg;

    localparam int RV_XLEN       = 32;
    localparam int ALU_CTL_WIDTH = 4;

    // ALU control codes, common to this decoder and the ALU it feeds.
    typedef enum logic [ALU_CTL_WIDTH-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_SEQ   = 4'd10,
        ALU_SNE   = 4'd11,
        ALU_SGE   = 4'd12,
        ALU_SGEU  = 4'd13,
        ALU_AUIPC = 4'd14
    } alu_ctl_e;

    typedef enum logic [1:0] {
        A_SEL_RS1  = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic {
        B_SEL_RS2 = 1'b0,
        B_SEL_IMM = 1'b1
    } b_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_ctl_e             ctl;
        a_sel_e               a_sel;
        b_sel_e               b_sel;
        logic [RV_XLEN-1:0]   imm;
        logic                 is_branch;
        logic                 illegal;
        logic [RV_XLEN-1:0]   pc;
    } payload_t;

    function automatic logic [RV_XLEN-1:0] imm_i(input logic [RV_XLEN-1:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [RV_XLEN-1:0] imm_s(input logic [RV_XLEN-1:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [RV_XLEN-1:0] imm_b(input logic [RV_XLEN-1:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [RV_XLEN-1:0] imm_j(input logic [RV_XLEN-1:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [RV_XLEN-1:0] imm_u(input logic [RV_XLEN-1:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    // AUIPC carries the raw upper field; the ALU applies the shift by 12.
    function automatic logic [RV_XLEN-1:0] imm_u_raw(input logic [RV_XLEN-1:0] instr);
        return {12'b0, instr[31:12]};
    endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// Purely combinational RV32I instruction-to-ALU-payload decode.
// Illegal encodings produce ADD with zero selects and immediate.
module alu_op_decode_comb
    import alu_op_decoder_pkg::*;
(
    input  logic [RV_XLEN-1:0] instr_i,
    input  logic [RV_XLEN-1:0] pc_i,
    output payload_t           payload_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       funct7_ok;
    logic       is_shift;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign funct7    = instr_i[31:25];
    assign funct7_ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);

    // sub_en distinguishes OP (ADD/SUB by funct7[5]) from OP-IMM (always ADD).
    function automatic alu_ctl_e arith_ctl(input logic [2:0] f3, input logic alt,
                                           input logic sub_en);
        alu_ctl_e ctl;
        case (f3)
            3'b000:  ctl = (alt && sub_en) ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = alt ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            default: ctl = ALU_AND;
        endcase
        return ctl;
    endfunction

    function automatic alu_ctl_e branch_ctl(input logic [2:0] f3);
        alu_ctl_e ctl;
        case (f3)
            3'b000:  ctl = ALU_SEQ;
            3'b001:  ctl = ALU_SNE;
            3'b100:  ctl = ALU_SLT;
            3'b101:  ctl = ALU_SGE;
            3'b110:  ctl = ALU_SLTU;
            default: ctl = ALU_SGEU;
        endcase
        return ctl;
    endfunction

    always_comb begin
        // NOTE: every field gets a default first so no path through the case leaves a latch.
        payload_o           = '0;
        payload_o.ctl       = ALU_ADD;
        payload_o.a_sel     = A_SEL_RS1;
        payload_o.b_sel     = B_SEL_RS2;
        payload_o.pc        = pc_i;

        case (opcode)
            OPC_OP: begin
                payload_o.illegal = !funct7_ok;
                payload_o.ctl     = arith_ctl(funct3, funct7[5], 1'b1);
            end
            OPC_OP_IMM: begin
                payload_o.illegal = is_shift && !funct7_ok;
                payload_o.ctl     = arith_ctl(funct3, funct7[5], 1'b0);
                payload_o.b_sel   = B_SEL_IMM;
                payload_o.imm     = imm_i(instr_i);
            end
            OPC_BRANCH: begin
                payload_o.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
                payload_o.ctl       = branch_ctl(funct3);
                payload_o.is_branch = 1'b1;
                payload_o.imm       = imm_b(instr_i);
            end
            OPC_LOAD, OPC_JALR: begin
                payload_o.b_sel = B_SEL_IMM;
                payload_o.imm   = imm_i(instr_i);
            end
            OPC_STORE: begin
                payload_o.b_sel = B_SEL_IMM;
                payload_o.imm   = imm_s(instr_i);
            end
            OPC_LUI: begin
                payload_o.a_sel = A_SEL_ZERO;
                payload_o.b_sel = B_SEL_IMM;
                payload_o.imm   = imm_u(instr_i);
            end
            OPC_AUIPC: begin
                payload_o.ctl   = ALU_AUIPC;
                payload_o.a_sel = A_SEL_PC;
                payload_o.b_sel = B_SEL_IMM;
                payload_o.imm   = imm_u_raw(instr_i);
            end
            OPC_JAL: begin
                payload_o.a_sel = A_SEL_PC;
                payload_o.b_sel = B_SEL_IMM;
                payload_o.imm   = imm_j(instr_i);
            end
            default: payload_o.illegal = 1'b1;
        endcase

        // Illegal encodings flow through as a harmless ADD of rs1 and rs2.
        if (payload_o.illegal) begin
            payload_o.ctl       = ALU_ADD;
            payload_o.a_sel     = A_SEL_RS1;
            payload_o.b_sel     = B_SEL_RS2;
            payload_o.imm       = '0;
            payload_o.is_branch = 1'b0;
        end
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered valid/ready stage between fetch and the ALU, wrapping the decode.
// Define ALU_OP_DECODER_SKID_EN to add a skid entry and register in_ready.
module alu_op_decoder
    import alu_op_decoder_pkg::*;
#(
    parameter int XLEN = RV_XLEN  // only 32 is supported
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ALU_CTL_WIDTH-1:0] out_ctl,
    output logic [1:0]               out_a_sel,
    output logic                     out_b_sel,
    output logic [XLEN-1:0]          out_imm,
    output logic                     out_is_branch,
    output logic                     out_illegal,
    output logic [XLEN-1:0]          out_pc
);

    payload_t decoded;
    payload_t payload_d, payload_q;
    logic     out_valid_d, out_valid_q;
    logic     push;
    logic     out_free;

    alu_op_decode_comb u_decode (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .payload_o (decoded)
    );

    assign push     = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

`ifdef ALU_OP_DECODER_SKID_EN
    payload_t skid_d, skid_q;
    logic     skid_valid_d, skid_valid_q;

    assign in_ready = !skid_valid_q;

    // in_ready is low whenever the skid is full, so a drain never coincides with a push.
    always_comb begin
        payload_d    = payload_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            if (skid_valid_q) begin
                payload_d    = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push) begin
                payload_d   = decoded;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_d       = decoded;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = out_free;

    always_comb begin
        payload_d   = payload_q;
        out_valid_d = out_valid_q;
        if (push) begin
            payload_d   = decoded;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload register is reset too, because its outputs must read zero in reset.
            payload_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
            payload_q   <= payload_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_ctl       = payload_q.ctl;
    assign out_a_sel     = payload_q.a_sel;
    assign out_b_sel     = payload_q.b_sel;
    assign out_imm       = payload_q.imm;
    assign out_is_branch = payload_q.is_branch;
    assign out_illegal   = payload_q.illegal;
    assign out_pc        = payload_q.pc;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: the driver queues hand-computed results,
// a monitor compares whenever the stage presents a payload.
module tb_alu_op_decoder;
    import alu_op_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_ctl;
    logic [1:0]  out_a_sel;
    logic        out_b_sel;
    logic [31:0] out_imm;
    logic        out_is_branch;
    logic        out_illegal;
    logic [31:0] out_pc;

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic        br;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   accept_cnt = 0;

    alu_op_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ctl       (out_ctl),
        .out_a_sel     (out_a_sel),
        .out_b_sel     (out_b_sel),
        .out_imm       (out_imm),
        .out_is_branch (out_is_branch),
        .out_illegal   (out_illegal),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input alu_ctl_e ctl, input logic [1:0] a,
                                input logic b, input logic [31:0] imm, input logic br,
                                input logic ill, input logic [31:0] pc);
        exp_t e;
        e.name = name; e.ctl = ctl; e.a = a; e.b = b;
        e.imm = imm; e.br = br; e.ill = ill; e.pc = pc;
        return e;
    endfunction

    // Monitor: compare the presented payload with the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                check({sb[0].name, ".ctl"},    {28'd0, out_ctl},       {28'd0, sb[0].ctl});
                check({sb[0].name, ".a_sel"},  {30'd0, out_a_sel},     {30'd0, sb[0].a});
                check({sb[0].name, ".b_sel"},  {31'd0, out_b_sel},     {31'd0, sb[0].b});
                check({sb[0].name, ".imm"},    out_imm,                sb[0].imm);
                check({sb[0].name, ".branch"}, {31'd0, out_is_branch}, {31'd0, sb[0].br});
                check({sb[0].name, ".illegal"},{31'd0, out_illegal},   {31'd0, sb[0].ill});
                check({sb[0].name, ".pc"},     out_pc,                 sb[0].pc);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] instr, input exp_t e);
        int waited = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = e.pc;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                check({e.name, ".accept_timeout"}, 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        sb.push_back(e);
        accept_cnt++;
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_cnt;
        // Reset state.
        #2;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_imm",   out_imm,            32'd0);
        check("rst.out_pc",    out_pc,             32'd0);
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Main decode vectors at full throughput.
        send(32'h002081B3, mk("add",    ALU_ADD,   2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00001000));
        send(32'h402081B3, mk("sub",    ALU_SUB,   2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00001004));
        send(32'h40335293, mk("srai",   ALU_SRA,   2'd0, 1'b1, 32'h00000403, 1'b0, 1'b0, 32'h00001008));
        send(32'h12345097, mk("auipc",  ALU_AUIPC, 2'd1, 1'b1, 32'h00012345, 1'b0, 1'b0, 32'h0000100C));
        send(32'h00209463, mk("bne",    ALU_SNE,   2'd0, 1'b0, 32'h00000008, 1'b1, 1'b0, 32'h00001010));
        send(32'hFFFFFFFF, mk("ill_ff", ALU_ADD,   2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00001014));
        send(32'h123450B7, mk("lui",    ALU_ADD,   2'd2, 1'b1, 32'h12345000, 1'b0, 1'b0, 32'h00001018));
        send(32'hFFC12083, mk("lw",     ALU_ADD,   2'd0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0000101C));
        send(32'h0020A423, mk("sw",     ALU_ADD,   2'd0, 1'b1, 32'h00000008, 1'b0, 1'b0, 32'h00001020));
        send(32'h010000EF, mk("jal",    ALU_ADD,   2'd1, 1'b1, 32'h00000010, 1'b0, 1'b0, 32'h00001024));
        send(32'h000080E7, mk("jalr",   ALU_ADD,   2'd0, 1'b1, 32'h00000000, 1'b0, 1'b0, 32'h00001028));
        send(32'h0020A463, mk("br_010", ALU_ADD,   2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h0000102C));
        send(32'hFE20FEE3, mk("bgeu",   ALU_SGEU,  2'd0, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h00001030));
        send(32'h022081B3, mk("op_f7",  ALU_ADD,   2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00001034));
        send(32'h02109093, mk("slli_f7",ALU_ADD,   2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00001038));
        send(32'hFFF12093, mk("slti",   ALU_SLT,   2'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0000103C));
        send(32'h0020B1B3, mk("sltu",   ALU_SLTU,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00001040));
        wait_drain();

        // Downstream stall for 5 cycles with a steady stream upstream.
        out_ready = 1'b0;
        base_cnt  = accept_cnt;
        fork
            begin
                send(32'h00A00093, mk("stall_a", ALU_ADD, 2'd0, 1'b1, 32'h0000000A, 1'b0, 1'b0, 32'h00002000));
                send(32'h0020C1B3, mk("stall_b", ALU_XOR, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00002004));
                send(32'h0020F1B3, mk("stall_c", ALU_AND, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00002008));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
`ifdef ALU_OP_DECODER_SKID_EN
                check("stall.accepted", accept_cnt - base_cnt, 32'd2);
`else
                check("stall.accepted", accept_cnt - base_cnt, 32'd1);
`endif
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset asserted mid-stall discards the held payload.
        out_ready = 1'b0;
        send(32'h0020E1B3, mk("rst_drop", ALU_OR, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00003000));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", {31'd0, out_valid},  32'd0);
        check("midrst.out_ctl",   {28'd0, out_ctl},    32'd0);
        check("midrst.out_imm",   out_imm,             32'd0);
        check("midrst.out_pc",    out_pc,              32'd0);
        check("midrst.in_ready",  {31'd0, in_ready},   32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h00209463, mk("post_rst", ALU_SNE, 2'd0, 1'b0, 32'h00000008, 1'b1, 1'b0, 32'h00004000));
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
Name: alu_op_decoder

Overview:
- Execute-side producer for the RV32I ALU: takes a fetched instruction plus PC and emits the ALU control code, operand-source selects and the formatted immediate.
- Registered, valid/ready-handshaked pipeline stage between fetch and the ALU.
- Payload is consumed directly by the datapath muxes in front of the ALU.

Parameters:
- XLEN, 32, instruction, PC and immediate width; only 32 supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  XLEN  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded payload valid
- out_ready  in  1  downstream accepts payload
- out_ctl  out  ALU_CTL_WIDTH  ALU control code (shared ALU defines)
- out_a_sel  out  2  operand A source: 0 = rs1, 1 = pc, 2 = zero
- out_b_sel  out  1  operand B source: 0 = rs2, 1 = imm
- out_imm  out  XLEN  formatted immediate
- out_is_branch  out  1  result is a branch condition
- out_illegal  out  1  unsupported encoding
- out_pc  out  XLEN  pass-through PC

Behaviour:
- Reset: asynchronous, takes effect immediately when rst_n low.
  - out_valid = 0; all payload outputs = 0.
  - in_ready follows its rule below from the reset state (empty stage).
- Handshakes:
  - Transfer on in_valid && in_ready (input) or out_valid && out_ready (output).
  - Latency: an accepted instruction appears on outputs the next cycle.
- Output register rules:
  - While out_valid && !out_ready, the payload is held stable and out_valid stays 1.
  - in_ready = !out_valid || out_ready (base build).
  - Simultaneous output pop and input push: the new payload loads the same cycle, so out_valid stays 1.
  - Pop without push: out_valid falls to 0.
- Decode, by opcode:
  - OP (0110011): funct3/funct7[5] select ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; a = rs1, b = rs2.
  - OP-IMM (0010011): same mapping except funct3 000 is always ADD; SRLI/SRAI use funct7[5]; a = rs1, b = imm (I-type, sign-extended).
  - BRANCH (1100011): funct3 000 SEQ, 001 SNE, 100 SLT, 101 SGE, 110 SLTU, 111 SGEU; a = rs1, b = rs2; out_is_branch = 1; imm = B-type sign-extended.
  - LOAD (0000011) and JALR (1100111): ADD, a = rs1, b = I-imm.
  - STORE (0100011): ADD, a = rs1, b = S-imm.
  - LUI (0110111): ADD, a = zero, b = imm = {instr[31:12], 12'b0}.
  - AUIPC (0010111): AUIPC code, a = pc, b = imm = zero-extended instr[31:12]; the ALU performs the <<12.
  - JAL (1101111): ADD, a = pc, b = J-imm.
- Illegal encodings: all other opcodes, funct3 010/011 in BRANCH, a shift with funct7 other than 0000000/0100000, and funct7 other than 0000000/0100000 in OP.
  - Set out_illegal = 1, out_ctl = ADD, selects and imm = 0.
  - Still handshaked normally; never stalls.
- Reset mid-transfer: the pending payload is discarded, no replay.

Optional Feature:
- Macro: ALU_OP_DECODER_SKID_EN.
- When defined:
  - Adds a one-entry skid register, so in_ready is a registered signal that does not depend combinationally on out_ready.
  - in_ready = !skid_valid.
  - An input accepted while the output is stalled goes to the skid register, then drains into the output register on the next pop.
  - Order is preserved; full throughput is kept.
- When undefined: single output register only, with in_ready = !out_valid || out_ready.
- Both builds give identical ordering and payload values.

Decomposition:
- Shared package: a_sel/b_sel enums, opcode constants, a decoded-payload struct, and the immediate-format helpers.
- ALU_CTL_WIDTH and ALU codes come from the existing shared ALU defines.
- One sub-module: alu_op_decode_comb, purely combinational instruction-to-payload logic; the top holds the registers, handshake and optional skid.

Test Plan:
- 0x002081B3 (add) then 0x402081B3 (sub), out_ready = 1 → one cycle each later: ctl ADD then SUB, a_sel 0, b_sel 0, illegal 0.
- 0x40335293 (srai x5,x6,3) → ctl SRA, b_sel 1, imm 0x00000403; 0x12345097 (auipc) → ctl AUIPC, a_sel 1, imm 0x00012345.
- 0x00209463 (bne x1,x2,+8) → ctl SNE, out_is_branch 1, imm 0x00000008.
- out_ready held 0 for 5 cycles with in_valid = 1 → payload stable, exactly one (base) or two (skid) instructions accepted, none lost or duplicated after release.
- 0xFFFFFFFF → out_illegal 1, ctl ADD, imm 0; the next valid instruction decodes normally.
- rst_n pulsed low mid-stall → out_valid 0 immediately; the first instruction after release decodes correctly.
